// File: rtl/seg_scan_if.sv
// Host-side and display-side signals of the multiplexed hex display controller.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic              en;
  logic              clear;
  logic [7:0]        data_in;
  logic              data_valid;
  logic [3:0]        nibble;
  logic [DIGITS-1:0] digit_en_n;
  logic              blank;
  logic              frame_tick;

  modport master (
    output en, clear, data_in, data_valid,
    input  nibble, digit_en_n, blank, frame_tick
  );

  modport slave (
    input  en, clear, data_in, data_valid,
    output nibble, digit_en_n, blank, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed hex display scanner: owns the digit shift register and drives
// one shared segment decoder per slot, with guard gaps and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GAP_CYC  = 500,
  parameter int LZ_EN    = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int CNT_MAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(DIGITS);

  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic {GAP, SHOW} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [3:0]          nibble_q, nibble_nxt;
  logic [DIGITS-1:0]   den_q, den_nxt;
  logic                blank_q, blank_nxt;
  logic                tick_q, tick_nxt;

  logic [4*DIGITS-1:0] value, value_nxt, shift_val;
  logic [3:0]          digit_sel;
  logic                upper_zero;
  logic                lz_hide;

  // With only two digits the whole register is replaced by the new byte.
  if (DIGITS == 2) begin : g_shift2
    assign shift_val = bus.data_in;
  end else begin : g_shiftn
    assign shift_val = {value[4*DIGITS-9:0], bus.data_in};
  end

  always_comb begin
    value_nxt = value;
    if (bus.clear)
      value_nxt = '0;
    else if (bus.data_valid)
      value_nxt = shift_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= '0;
    else
      value <= value_nxt;
  end

  assign digit_sel = value[{idx, 2'b00} +: 4];

  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i >= 32'(idx) && value[4*i +: 4] != 4'h0)
        upper_zero = 1'b0;
    end
    lz_hide = (LZ_EN != 0) && (idx != '0) && upper_zero;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CW'(1);
    idx_nxt    = idx;
    nibble_nxt = nibble_q;
    den_nxt    = den_q;
    blank_nxt  = blank_q;
    tick_nxt   = 1'b0;

    if (!bus.en) begin
      state_nxt = GAP;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      den_nxt   = '1;
      blank_nxt = 1'b1;
    end else begin
      unique case (state)
        GAP: begin
          if (cnt == GAP_LAST) begin
            state_nxt  = SHOW;
            cnt_nxt    = '0;
            nibble_nxt = digit_sel;
            // A suppressed slot keeps full length so the frame period never changes.
            if (lz_hide) begin
              den_nxt   = '1;
              blank_nxt = 1'b1;
            end else begin
              den_nxt   = ~(DIGITS'(1) << idx);
              blank_nxt = 1'b0;
            end
          end
        end
        SHOW: begin
          if (cnt == SCAN_LAST) begin
            state_nxt = GAP;
            cnt_nxt   = '0;
            den_nxt   = '1;
            blank_nxt = 1'b1;
            if (idx == IDX_LAST) begin
              idx_nxt  = '0;
              tick_nxt = 1'b1;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end
        end
        default: begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GAP;
      cnt      <= '0;
      idx      <= '0;
      nibble_q <= '0;
      den_q    <= '1;
      blank_q  <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      nibble_q <= nibble_nxt;
      den_q    <= den_nxt;
      blank_q  <= blank_nxt;
      tick_q   <= tick_nxt;
    end
  end

  assign bus.nibble     = nibble_q;
  assign bus.digit_en_n = den_q;
  assign bus.blank      = blank_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench: a slot-arithmetic model predicts every cycle's outputs for
// two instances (leading-zero suppression off and on) driven with identical stimulus.
module tb_seg_scan_ctrl;

  localparam int D   = 4;
  localparam int SD  = 4;
  localparam int GC  = 2;
  localparam int P   = SD + GC;
  localparam int FRM = D * P;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(D)) bus0 ();
  seg_scan_if #(.DIGITS(D)) bus1 ();

  seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .GAP_CYC(GC), .LZ_EN(0)) u_lz0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .GAP_CYC(GC), .LZ_EN(1)) u_lz1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  typedef struct {
    logic [3:0] den;
    logic       blank;
    logic [3:0] nib;
    logic       tick;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic e, input logic c, input logic v, input logic [7:0] d);
    bus0.en = e; bus0.clear = c; bus0.data_valid = v; bus0.data_in = d;
    bus1.en = e; bus1.clear = c; bus1.data_valid = v; bus1.data_in = d;
  endtask

  // Reference model: position in the frame follows from cycles since scan start.
  logic [15:0] mval = '0;
  int          t = 0;
  logic [3:0]  mnib = '0;
  logic        msup [2] = '{1'b0, 1'b0};
  bit          stepped = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mval = '0; t = 0; mnib = '0; msup[0] = 1'b0; msup[1] = 1'b0;
      q0.delete(); q1.delete(); stepped = 1'b0;
    end else begin
      logic [15:0] old;
      int phase, slot;
      logic lit, tick;
      exp_t e;
      old = mval;
      if (bus0.clear) mval = '0;
      else if (bus0.data_valid) mval = {mval[7:0], bus0.data_in};
      if (bus0.en) t = t + 1; else t = 0;
      phase = t % P;
      slot  = (t / P) % D;
      if (bus0.en && phase == GC) begin
        mnib = old[4*slot +: 4];
        msup[0] = 1'b0;
        msup[1] = (slot != 0) && ((old >> (4*slot)) == 16'h0);
      end
      lit  = bus0.en && (phase >= GC);
      tick = bus0.en && (t % FRM == 0);
      for (int lz = 0; lz < 2; lz++) begin
        e.den   = (lit && !msup[lz]) ? ~(4'b0001 << slot) : 4'hF;
        e.blank = !(lit && !msup[lz]);
        e.nib   = mnib;
        e.tick  = tick;
        if (lz == 0) q0.push_back(e); else q1.push_back(e);
      end
      stepped = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && stepped) begin
      exp_t e;
      cmp("q0_has_entry", int'(q0.size() > 0), 1);
      cmp("q1_has_entry", int'(q1.size() > 0), 1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("lz0_digit_en_n", bus0.digit_en_n, e.den);
        cmp("lz0_blank", bus0.blank, e.blank);
        cmp("lz0_nibble", bus0.nibble, e.nib);
        cmp("lz0_frame_tick", bus0.frame_tick, e.tick);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("lz1_digit_en_n", bus1.digit_en_n, e.den);
        cmp("lz1_blank", bus1.blank, e.blank);
        cmp("lz1_nibble", bus1.nibble, e.nib);
        cmp("lz1_frame_tick", bus1.frame_tick, e.tick);
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b1, d);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_den(input logic [3:0] pat, input logic [3:0] nib, input bit use_nib,
                          input string nm);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (bus0.digit_en_n == pat && (!use_nib || bus0.nibble == nib)) found = 1'b1;
    end
    cmp(nm, int'(found), 1);
  endtask

  initial begin
    int off;
    logic e_v;
    set_in(1'b1, 1'b0, 1'b0, 8'h00);
    #23;
    @(negedge clk);
    rst_n = 1'b1;

    idle(30);
    send(8'h3C);
    send(8'hA5);
    idle(30);
    send(8'h01);
    idle(30);

    @(negedge clk);
    set_in(1'b1, 1'b1, 1'b1, 8'hFF);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 8'h00);
    idle(30);
    send(8'h07);
    idle(30);

    send(8'h3C);
    send(8'hA5);
    wait_den(4'b1110, 4'h5, 1'b1, "wait_digit0_nib5");
    set_in(1'b1, 1'b0, 1'b1, 8'h99);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 8'h00);
    idle(30);

    wait_den(4'b1011, 4'h0, 1'b0, "wait_digit2");
    set_in(1'b0, 1'b0, 1'b0, 8'h00);
    idle(3);
    set_in(1'b1, 1'b0, 1'b0, 8'h00);
    idle(10);

    wait_den(4'b1110, 4'h0, 1'b0, "wait_lit_for_reset");
    #2 rst_n = 1'b0;
    #1;
    cmp("rst_lz0_digit_en_n", bus0.digit_en_n, 4'hF);
    cmp("rst_lz0_blank", bus0.blank, 1);
    cmp("rst_lz0_nibble", bus0.nibble, 0);
    cmp("rst_lz0_frame_tick", bus0.frame_tick, 0);
    cmp("rst_lz1_digit_en_n", bus1.digit_en_n, 4'hF);
    cmp("rst_lz1_blank", bus1.blank, 1);
    cmp("rst_lz1_nibble", bus1.nibble, 0);
    idle(2);
    rst_n = 1'b1;
    idle(30);

    off = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (off > 0) off--;
      else if ($urandom_range(0, 199) == 0) off = int'($urandom_range(1, 12));
      e_v = (off == 0);
      set_in(e_v, ($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
    end
    set_in(1'b1, 1'b0, 1'b0, 8'h00);
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
